rw_addr_feeder: RTL and testbench
=================================

# rw_addr_feeder

Upstream address feeder for the 8-entry read-modify-write increment memory stage. Accepts bin addresses over a valid/ready handshake and buffers them in a small FIFO. Presents them one per cycle, registered, on `io_addr` with a qualifying `io_addr_valid`; integration gates the downstream write enable with that valid. Also runs a sweep sequence that visits every bin once, in ascending order.

## Interface

Parameters:
- `ADDR_W`, 32: address width on input and output.
- `BINS`, 8: number of downstream memory entries; must be a power of two.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `io_in_valid`  in  1: producer has an address.
- `io_in_ready`  out  1: feeder can accept; equals FIFO not full, state not SWEEP_PEND/SWEEP, and `reset` low.
- `io_in_bits`  in  ADDR_W: incoming bin address.
- `io_sweep`  in  1: single-cycle sweep request.
- `io_addr_valid`  out  1: `io_addr` is a real request this cycle.
- `io_addr`  out  ADDR_W: address to the increment stage; registered.
- `io_busy`  out  1: FIFO non-empty, output valid, or state ≠ IDLE.
- `io_drop_count`  out  16: saturating count of rejected out-of-range addresses.

## Operation

- Transfer: `io_in_valid & io_in_ready` sampled at a rising edge.
- Downstream has no backpressure, so the output register reloads every cycle:
  - FIFO non-empty: FIFO head is popped into the output register.
  - FIFO empty with a transfer this cycle: the transfer bypasses the FIFO into the output register.
  - Otherwise: `io_addr_valid` is 0 and `io_addr` holds its last value.
- A transfer that is not bypassed is pushed. There is no push while full, even if a pop happens in the same cycle.
- Ordering is strictly FIFO; addresses pass through unmodified (zero-extended semantics; no truncation).
- States:
  - IDLE: normal accept/drain.
  - SWEEP_PEND: sweep requested; input blocked while the FIFO drains.
  - SWEEP: emits 0..BINS-1 on consecutive cycles, `io_addr_valid`=1 on each.
- Transitions:
  - IDLE, `io_sweep`=1, FIFO empty → SWEEP. First sweep address appears next cycle.
  - IDLE, `io_sweep`=1, FIFO non-empty → SWEEP_PEND.
  - SWEEP_PEND, FIFO empty after the current pop → SWEEP.
  - SWEEP, after emitting BINS-1 → IDLE. `io_in_ready` reasserts the cycle after the last sweep address is emitted.
- `io_sweep` in SWEEP_PEND or SWEEP is ignored (no queuing of a second sweep).
- A transfer in the same cycle as `io_sweep` in IDLE is accepted and emitted before the sweep.
- Sweep counter is log2(BINS) bits and zero-extended to ADDR_W.

## Timing

- Reset values:
  - `io_addr_valid`=0, `io_addr`=0, `io_drop_count`=0, state IDLE, FIFO empty.
  - `io_busy`=0; `io_in_ready`=0 while `reset`=1, 1 the first cycle after.
- Latency: a transfer at edge N with the FIFO empty gives `io_addr_valid`=1 with that address in the cycle after edge N (1 cycle).
- Throughput: one address per cycle sustained; a full FIFO deasserts `io_in_ready` the cycle it fills.
- Sweep duration: exactly BINS consecutive valid cycles; no gap between SWEEP_PEND's last drained address and address 0.
- `reset` mid-sweep or with a non-empty FIFO discards everything at that edge; no partial sequence resumes.

## Configuration

- `RW_FEEDER_RANGE_CHECK_EN` defined:
  - A transfer with `io_in_bits` ≥ BINS is accepted (handshake completes) but neither pushed nor emitted.
  - `io_drop_count` increments by 1 per such transfer, saturating at 0xFFFF.
- Undefined:
  - All addresses pass through (downstream aliases on the low bits).
  - `io_drop_count` is constant 0 and its counter logic is absent.

## Test plan

- Reset then single transfer 0x5 at edge N → cycle after N: `io_addr_valid`=1, `io_addr`=0x5; next cycle `io_addr_valid`=0; `io_busy` returns 0.
- Burst 1,2,3,4,5,6 with `io_in_valid` held high → outputs 1..6 in order, one per cycle, no loss; `io_in_ready` never drops (pops keep pace).
- Sweep from empty IDLE → `io_addr` 0..7 on 8 consecutive valid cycles; `io_in_ready`=0 throughout; `io_sweep` pulsed mid-sweep ignored, so exactly 8 addresses.
- Fill FIFO with 3,3,3 then pulse `io_sweep` → 3,3,3 (plus any in-flight address) then 0..7 with no idle gap; input blocked from the request until sweep ends.
- With `RW_FEEDER_RANGE_CHECK_EN`: send 0x2, 0x8, 0xFFFFFFFF, 0x7 → outputs 0x2, 0x7 only; `io_drop_count`=2. Without the macro → all four emitted; count stays 0.
- Assert `reset` during sweep at address 3 → next cycle `io_addr_valid`=0, `io_addr`=0, `io_busy`=0; a new sweep restarts at 0.

Source files
------------

// File: rtl/rw_addr_feeder.sv
// rw_addr_feeder: buffers bin addresses and presents one registered address per cycle; can also sweep every bin in ascending order.
// Optional feature: define RW_FEEDER_RANGE_CHECK_EN to drop and count addresses >= BINS.
module rw_addr_feeder #(
    parameter int ADDR_W = 32,
    parameter int BINS   = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [ADDR_W-1:0] io_in_bits,
    input  logic              io_sweep,
    output logic              io_addr_valid,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_busy,
    output logic [15:0]       io_drop_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (BINS > 1) ? $clog2(BINS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP_PEND,
        SWEEP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [CNT_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic              addr_valid_q, addr_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic fifo_empty, fifo_full, xfer, in_range, keep, push, pop;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (PTR_W+1)'(DEPTH));
    assign io_in_ready = !fifo_full && (state_q == IDLE) && !reset;
    assign xfer        = io_in_valid && io_in_ready;

`ifdef RW_FEEDER_RANGE_CHECK_EN
    assign in_range = (io_in_bits < ADDR_W'(BINS));
`else
    assign in_range = 1'b1;
`endif

    // An accepted address bypasses the FIFO whenever the FIFO is empty.
    assign keep = xfer && in_range;
    assign pop  = (state_q != SWEEP) && !fifo_empty;
    assign push = keep && !fifo_empty && !fifo_full;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;

        if (state_q == SWEEP) begin
            addr_valid_d = 1'b1;
            addr_d       = ADDR_W'(sweep_cnt_q);
        end else if (pop) begin
            addr_valid_d = 1'b1;
            addr_d       = mem_q[rd_ptr_q];
        end else if (keep) begin
            addr_valid_d = 1'b1;
            addr_d       = io_in_bits;
        end

        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        unique case (state_q)
            IDLE: begin
                if (io_sweep) state_d = fifo_empty ? SWEEP : SWEEP_PEND;
            end
            SWEEP_PEND: begin
                // Input is blocked here, so the FIFO is empty after this pop once count <= 1.
                if (count_q <= (PTR_W+1)'(1)) state_d = SWEEP;
            end
            SWEEP: begin
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                if (sweep_cnt_q == CNT_W'(BINS - 1)) begin
                    state_d     = IDLE;
                    sweep_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sweep_cnt_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= io_in_bits;
    end

`ifdef RW_FEEDER_RANGE_CHECK_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (xfer && !in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign io_drop_count = drop_q;
`else
    assign io_drop_count = '0;
`endif

    assign io_addr_valid = addr_valid_q;
    assign io_addr       = addr_q;
    assign io_busy       = !fifo_empty || addr_valid_q || (state_q != IDLE);
endmodule

// File: tb/tb_rw_addr_feeder.sv
// Self-checking bench for rw_addr_feeder: directed vector table, hand-written sweep/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rw_addr_feeder;
    localparam int ADDR_W = 32;
    localparam int BINS   = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [ADDR_W-1:0] io_in_bits;
    logic              io_sweep;
    logic              io_addr_valid;
    logic [ADDR_W-1:0] io_addr;
    logic              io_busy;
    logic [15:0]       io_drop_count;

    rw_addr_feeder #(.ADDR_W(ADDR_W), .BINS(BINS), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_bits    (io_in_bits),
        .io_sweep      (io_sweep),
        .io_addr_valid (io_addr_valid),
        .io_addr       (io_addr),
        .io_busy       (io_busy),
        .io_drop_count (io_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

`ifdef RW_FEEDER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // Reference model: pending addresses as a queue, a mode (0 idle, 1 waiting to sweep, 2 sweeping).
    logic [ADDR_W-1:0] m_q[$];
    int                m_mode = 0;
    int                m_sidx = 0;
    logic              m_valid = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_drops = 0;

    function automatic logic m_ready(input logic rst);
        return !rst && (m_q.size() < DEPTH) && (m_mode == 0);
    endfunction

    task automatic model_edge(input logic rst, input logic v, input logic [ADDR_W-1:0] b, input logic s);
        int   pre;
        logic xfer, keep, used;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_sidx = 0; m_valid = 1'b0; m_addr = '0; m_drops = 0;
            return;
        end
        pre  = m_q.size();
        xfer = v && m_ready(1'b0);
        keep = xfer;
        if (RANGE_EN && xfer && (b >= BINS)) begin
            keep = 1'b0;
            if (m_drops < 65535) m_drops++;
        end
        used = 1'b0;
        if (m_mode == 2) begin
            m_valid = 1'b1; m_addr = ADDR_W'(m_sidx);
        end else if (pre > 0) begin
            m_valid = 1'b1; m_addr = m_q.pop_front();
        end else if (keep) begin
            m_valid = 1'b1; m_addr = b; used = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (keep && !used) m_q.push_back(b);
        case (m_mode)
            0: if (s) m_mode = (pre == 0) ? 2 : 1;
            1: if (m_q.size() == 0) m_mode = 2;
            default: begin
                m_sidx++;
                if (m_sidx == BINS) begin m_sidx = 0; m_mode = 0; end
            end
        endcase
    endtask

    // One clock: drive inputs, check ready before the edge, then check all outputs after it.
    task automatic step(input logic rst, input logic v, input logic [ADDR_W-1:0] b, input logic s);
        reset = rst; io_in_valid = v; io_in_bits = b; io_sweep = s;
        #1;
        check("model_ready", 32'(io_in_ready), 32'(m_ready(rst)));
        @(posedge clk);
        model_edge(rst, v, b, s);
        #1;
        check("model_valid", 32'(io_addr_valid), 32'(m_valid));
        check("model_addr", io_addr, m_addr);
        check("model_busy", 32'(io_busy), 32'((m_q.size() != 0) || m_valid || (m_mode != 0)));
        check("model_drops", 32'(io_drop_count), 32'(m_drops));
    endtask

    typedef struct {
        logic              rst;
        logic              v;
        logic [ADDR_W-1:0] bits;
        logic              sw;
        logic              ev;
        logic [ADDR_W-1:0] ea;
        logic              eb;
        logic              er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [ADDR_W-1:0] bits, input logic sw,
                       input logic ev, input logic [ADDR_W-1:0] ea, input logic eb, input logic er);
        vec_t r;
        r.rst = rst; r.v = v; r.bits = bits; r.sw = sw;
        r.ev = ev; r.ea = ea; r.eb = eb; r.er = er;
        vecs.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              got_v [11];
        logic [ADDR_W-1:0] got_a [11];
        logic              got_r [11];
        logic [ADDR_W-1:0] exp_a [11];
        logic              exp_r [11];
        bit                found;

        reset = 1'b1; io_in_valid = 1'b0; io_in_bits = '0; io_sweep = 1'b0;

        // Directed table: {rst, valid, bits, sweep} -> {addr_valid, addr, busy, ready after edge}
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(0, 1, 5, 0,   1, 5, 1, 1);
        add(0, 0, 0, 0,   0, 5, 0, 1);
        for (int k = 1; k <= 6; k++) add(0, 1, ADDR_W'(k), 0, 1, ADDR_W'(k), 1, 1);
        add(0, 0, 0, 0,   0, 6, 0, 1);
        add(0, 0, 0, 1,   0, 6, 1, 0);
        add(0, 0, 0, 0,   1, 0, 1, 0);
        add(0, 1, 9, 0,   1, 1, 1, 0);
        add(0, 0, 0, 0,   1, 2, 1, 0);
        add(0, 0, 0, 1,   1, 3, 1, 0);
        add(0, 0, 0, 0,   1, 4, 1, 0);
        add(0, 0, 0, 0,   1, 5, 1, 0);
        add(0, 0, 0, 0,   1, 6, 1, 0);
        add(0, 0, 0, 0,   1, 7, 1, 1);
        add(0, 0, 0, 0,   0, 7, 0, 1);
        add(0, 1, 2, 0,   1, 2, 1, 1);
        if (RANGE_EN) begin
            add(0, 1, 8, 0,            0, 2, 0, 1);
            add(0, 1, 32'hFFFF_FFFF, 0, 0, 2, 0, 1);
        end else begin
            add(0, 1, 8, 0,            1, 8, 1, 1);
            add(0, 1, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 1, 1);
        end
        add(0, 1, 7, 0,   1, 7, 1, 1);
        add(0, 0, 0, 0,   0, 7, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].bits, vecs[i].sw);
            check($sformatf("vec%0d_valid", i), 32'(io_addr_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_addr", i), io_addr, vecs[i].ea);
            check($sformatf("vec%0d_busy", i), 32'(io_busy), 32'(vecs[i].eb));
            check($sformatf("vec%0d_ready", i), 32'(io_in_ready), 32'(vecs[i].er));
        end
        check("drop_count_after_table", 32'(io_drop_count), RANGE_EN ? 32'd2 : 32'd0);

        // 3,3,3 with the sweep requested alongside the last one: 3,3,3 then 0..7 with no gap.
        for (int c = 0; c < 11; c++) begin
            step(0, c < 3, 3, c == 2);
            got_v[c] = io_addr_valid; got_a[c] = io_addr; got_r[c] = io_in_ready;
            exp_a[c] = (c < 3) ? 3 : ADDR_W'(c - 3);
            exp_r[c] = (c < 2) || (c == 10);
        end
        for (int c = 0; c < 11; c++) begin
            check($sformatf("seq333_valid%0d", c), 32'(got_v[c]), 32'd1);
            check($sformatf("seq333_addr%0d", c), got_a[c], exp_a[c]);
            check($sformatf("seq333_ready%0d", c), 32'(got_r[c]), 32'(exp_r[c]));
        end
        step(0, 0, 0, 0);
        check("seq333_idle_after", 32'(io_addr_valid), 32'd0);

        // Reset while address 3 of a sweep is on the output, then a fresh sweep starts at 0.
        step(0, 0, 0, 1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(0, 0, 0, 0);
            if (io_addr_valid && io_addr == 3) found = 1'b1;
        end
        check("reset_sweep_reached_3", 32'(found), 32'd1);
        step(1, 0, 0, 0);
        check("reset_sweep_valid", 32'(io_addr_valid), 32'd0);
        check("reset_sweep_addr", io_addr, 32'd0);
        check("reset_sweep_busy", 32'(io_busy), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("restart_sweep_valid", 32'(io_addr_valid), 32'd1);
        check("restart_sweep_addr", io_addr, 32'd0);
        for (int c = 0; c < BINS; c++) step(0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [ADDR_W-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, BINS - 1));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, b, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
